// File: rtl/bin2bcd_hex_display.sv
// bin2bcd_hex_display: accepts a 32-bit unsigned value over a valid/ready
// handshake and converts it with a 32-iteration double-dabble engine to
// ten BCD digits. The eight low digits drive active-low 7-segment outputs
// {g,f,e,d,c,b,a}. Any nonzero digit above digit 7 (value > 99_999_999)
// raises o_ovf and shows dashes on every digit.
//
// Optional feature macro: BIN2BCD_LZ_BLANK_EN
//   defined   -> leading-zero blanking (digits above the most significant
//                nonzero digit show 7'h7F; o_hex0 and dashes never blank)
//   undefined -> all eight digits are always shown
//
// Handshake: a transfer happens on a rising edge where i_valid && o_ready.
// o_ready is high only while the engine is IDLE. i_data is sampled only on
// that edge. Upstream holds i_valid until it is accepted, and a valid
// presented while o_ready is low is ignored (there is no queueing).
module bin2bcd_hex_display (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  output logic        o_ready,
  output logic        o_ovf,
  output logic [6:0]  o_hex0,
  output logic [6:0]  o_hex1,
  output logic [6:0]  o_hex2,
  output logic [6:0]  o_hex3,
  output logic [6:0]  o_hex4,
  output logic [6:0]  o_hex5,
  output logic [6:0]  o_hex6,
  output logic [6:0]  o_hex7
);

  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [6:0] HEX_HI_RST = SEG_OFF;
`else
  localparam logic [6:0] HEX_HI_RST = SEG_ZERO;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Active-low segment code for a single BCD digit.
  // Digit 9 is drawn without the bottom segment d.
  function automatic logic [6:0] bcd_to_7seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0011000;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_bin;
  logic [39:0]      r_bcd;
  logic [4:0]       r_cnt;
  logic             r_ovf;
  logic [7:0][6:0]  r_hex;
  logic [39:0]      w_bcd_adj;
  logic             w_ovf;
  logic [7:0][6:0]  w_hex;
  logic             w_hs;

  assign w_hs    = i_valid && (r_state == S_IDLE);
  assign o_ready = (r_state == S_IDLE);
  assign o_ovf   = r_ovf;
  assign o_hex0  = r_hex[0];
  assign o_hex1  = r_hex[1];
  assign o_hex2  = r_hex[2];
  assign o_hex3  = r_hex[3];
  assign o_hex4  = r_hex[4];
  assign o_hex5  = r_hex[5];
  assign o_hex6  = r_hex[6];
  assign o_hex7  = r_hex[7];

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: one IDLE cycle per handshake, 32 shifts, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_state_nxt = S_CONV;
      S_CONV:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 10; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Display encoding of the finished accumulator, with dashes on overflow
  // and optional leading-zero blanking (scanning down from digit 7).
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    w_ovf     = (r_bcd[39:32] != 8'd0);
    w_hex     = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_bcd[4*i +: 4] != 4'd0) lead_zero = 1'b0;
      if (w_ovf) begin
        w_hex[i] = SEG_DASH;
      end else begin
        w_hex[i] = bcd_to_7seg(r_bcd[4*i +: 4]);
`ifdef BIN2BCD_LZ_BLANK_EN
        if (lead_zero && (i != 0)) w_hex[i] = SEG_OFF;
`endif
      end
    end
  end

  // Datapath: load on handshake, shift during CONV, publish on DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_hex[0] <= SEG_ZERO;
      for (int i = 1; i < 8; i++) r_hex[i] <= HEX_HI_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_bin <= i_data;
            r_bcd <= '0;
            r_cnt <= '0;
          end
        end
        S_CONV: begin
          r_bcd <= {w_bcd_adj[38:0], r_bin[31]};
          r_bin <= {r_bin[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
        end
        S_DONE: begin
          r_ovf <= w_ovf;
          r_hex <= w_hex;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_hex_display.sv
// Testbench for bin2bcd_hex_display: a decimal reference model (divide by
// ten, compare against 99_999_999, busy countdown of 33 cycles after each
// accepted value) is checked against the DUT on every falling edge, plus
// directed vectors with hand-computed segment literals.
module tb_bin2bcd_hex_display;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [6:0] HI_RST = 7'h7F;
  localparam bit LZ = 1'b1;
`else
  localparam logic [6:0] HI_RST = 7'b1000000;
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst, i_valid;
  logic [31:0] i_data;
  logic        o_ready, o_ovf;
  logic [6:0]  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bin2bcd_hex_display dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_ovf(o_ovf),
    .o_hex0(o_hex0), .o_hex1(o_hex1), .o_hex2(o_hex2), .o_hex3(o_hex3),
    .o_hex4(o_hex4), .o_hex5(o_hex5), .o_hex6(o_hex6), .o_hex7(o_hex7)
  );

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0011000};
  int          m_busy = 0;
  logic [31:0] m_val  = '0;
  logic [6:0]  m_hex [8];
  logic        m_ovf  = 1'b0;

  task automatic model_display(input logic [31:0] v);
    longint rest;
    longint pow;
    rest  = longint'(v);
    pow   = 1;
    m_ovf = (longint'(v) > 64'd99_999_999);
    for (int i = 0; i < 8; i++) begin
      if (m_ovf)                             m_hex[i] = 7'b0111111;
      else if (LZ && i > 0 && longint'(v) < pow) m_hex[i] = 7'h7F;
      else                                   m_hex[i] = seg_tab[rest % 10];
      rest = rest / 10;
      pow  = pow * 10;
    end
  endtask

  always @(posedge clk) begin
    if (i_rst) begin
      m_busy   = 0;
      m_ovf    = 1'b0;
      m_hex[0] = 7'b1000000;
      for (int i = 1; i < 8; i++) m_hex[i] = HI_RST;
    end else if (m_busy == 0) begin
      if (i_valid) begin
        m_val  = i_data;
        m_busy = 33;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) model_display(m_val);
    end
  end

  // ---------------- scoreboard: every cycle against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", o_ready, (m_busy == 0));
      check("ovf",   o_ovf,   m_ovf);
      check("hex0",  o_hex0,  m_hex[0]);
      check("hex1",  o_hex1,  m_hex[1]);
      check("hex2",  o_hex2,  m_hex[2]);
      check("hex3",  o_hex3,  m_hex[3]);
      check("hex4",  o_hex4,  m_hex[4]);
      check("hex5",  o_hex5,  m_hex[5]);
      check("hex6",  o_hex6,  m_hex[6]);
      check("hex7",  o_hex7,  m_hex[7]);
    end
  end

  // ---------------- driver tasks ----------------
  // Present v and wait for acceptance; returns the number of cycles waited.
  task automatic send(input logic [31:0] v, input bit hold, output int waited);
    i_valid = 1'b1;
    i_data  = v;
    waited  = 0;
    while (!o_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    if (!hold) i_valid = 1'b0;
  endtask

  // Count cycles with o_ready low (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int n;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    chk_en = 1'b1;

    // Reset values
    check("rst_ready", o_ready, 1);
    check("rst_ovf",   o_ovf,   0);
    check("rst_hex0",  o_hex0,  7'b1000000);
    check("rst_hex7",  o_hex7,  HI_RST);

    // Normal conversion: 12_345_678
    send(32'd12_345_678, 1'b0, w);
    wait_idle(n);
    check("lat_12345678", n, 33);
    check("n_hex7", o_hex7, 7'b1111001);
    check("n_hex6", o_hex6, 7'b0100100);
    check("n_hex3", o_hex3, 7'b0010010);
    check("n_hex0", o_hex0, 7'b0000000);
    check("n_ovf",  o_ovf,  0);
    check("model_hex7", m_hex[7], 7'b1111001);
    check("model_hex0", m_hex[0], 7'b0000000);

    // Blanking: 905
    send(32'd905, 1'b0, w);
    wait_idle(n);
    check("b_hex2", o_hex2, 7'b0011000);
    check("b_hex1", o_hex1, 7'b1000000);
    check("b_hex0", o_hex0, 7'b0010010);
    check("b_hex3", o_hex3, LZ ? 7'h7F : 7'b1000000);
    check("b_hex7", o_hex7, LZ ? 7'h7F : 7'b1000000);

    // Overflow boundary
    send(32'd99_999_999, 1'b0, w);
    wait_idle(n);
    check("max_hex7", o_hex7, 7'b0011000);
    check("max_hex0", o_hex0, 7'b0011000);
    check("max_ovf",  o_ovf,  0);
    send(32'd100_000_000, 1'b0, w);
    wait_idle(n);
    check("ov_hex7", o_hex7, 7'b0111111);
    check("ov_hex0", o_hex0, 7'b0111111);
    check("ov_ovf",  o_ovf,  1);
    check("model_ov_hex3", m_hex[3], 7'b0111111);
    send(32'hFFFF_FFFF, 1'b0, w);
    wait_idle(n);
    check("ff_hex4", o_hex4, 7'b0111111);
    check("ff_ovf",  o_ovf,  1);

    // Value zero
    send(32'd0, 1'b0, w);
    wait_idle(n);
    check("z_lat",  n, 33);
    check("z_hex0", o_hex0, 7'b1000000);
    check("z_hex1", o_hex1, LZ ? 7'h7F : 7'b1000000);
    check("z_ovf",  o_ovf,  0);

    // Busy and stability: 7 then 3 back to back with i_valid held
    send(32'd7, 1'b1, w);
    i_data = 32'd3;
    wait_idle(n);
    check("bb_busy", n, 33);
    check("bb_hex0_7", o_hex0, 7'b1111000);
    @(posedge clk); #1;                 // second handshake at T+34
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 i_data = 32'd9;                  // mid-conversion change is ignored
    wait_idle(n);
    check("bb_busy2", n, 28);
    check("bb_hex0_3", o_hex0, 7'b0110000);
    check("bb_hex1", o_hex1, LZ ? 7'h7F : 7'b1000000);

    // Reset mid-operation
    send(32'd42, 1'b0, w);
    wait_idle(n);
    check("r_hex1_4", o_hex1, 7'b0011001);
    check("r_hex0_2", o_hex0, 7'b0100100);
    send(32'd77, 1'b0, w);              // now in cycle T+1
    repeat (9) @(posedge clk);
    #1 i_rst = 1'b1;                    // asserted during T+10
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("mr_ready", o_ready, 1);
    check("mr_hex0",  o_hex0,  7'b1000000);
    check("mr_hex1",  o_hex1,  HI_RST);
    check("mr_ovf",   o_ovf,   0);
    repeat (40) @(posedge clk);
    #1;
    check("mr_no77_hex0", o_hex0, 7'b1000000);
    check("mr_no77_hex1", o_hex1, HI_RST);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_hex_display.md
# bin2bcd_hex_display

Sequential binary-to-decimal display driver for the single-cycle RV32I core's output port. Accepts a 32-bit unsigned value from the memory-mapped I/O register over a valid/ready handshake and converts it to eight BCD digits with a multi-cycle double-dabble engine. It then encodes each digit with the package's `bcd_to_7seg` function and holds the result on eight active-low 7-segment outputs. It sits between the core's LSU output register and the board HEX pins.

## Interface
- No parameters; data width is fixed at 32 bits and digit count at 8.
- `i_clk` in 1: sole clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: `i_data` holds a new value to display.
- `i_data` in 32: unsigned binary value.
- `o_ready` out 1: engine idle, transfer accepted when `i_valid && o_ready`.
- `o_ovf` out 1: last converted value exceeded 99_999_999.
- `o_hex0`..`o_hex7` out 7 each: active-low segments `{g,f,e,d,c,b,a}`. `o_hex0` carries the least significant digit.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - `o_ready`=1.
  - On handshake, load `i_data` into a 32-bit shift register, clear the 40-bit BCD accumulator (10 digits) and clear the 5-bit iteration counter, then go to CONV.
- **CONV**
  - Each cycle, every accumulator nibble ≥5 gets +3 (combinational), then `{bcd, bin}` shifts left by 1 and the counter increments.
  - After the 32nd shift (counter was 31), go to DONE.
- **DONE**
  - `o_ovf` is set to (digit9|digit8 != 0).
  - If overflow, all `o_hexN` = 7'b0111111 (dash).
  - Otherwise `o_hexN` = `bcd_to_7seg(digitN)`.
  - All outputs register in the same edge, then go to IDLE.
- `i_valid` while `o_ready`=0 is ignored. There is no queueing, and the upstream must hold `i_valid` until accepted.
- `i_data` is sampled only at the handshake edge; later changes have no effect on the conversion.
- Display outputs and `o_ovf` change only on the DONE edge or on reset.

## Timing
- Handshake at the edge ending cycle T.
- CONV occupies cycles T+1..T+32 and DONE occupies cycle T+33.
- New `o_hexN`/`o_ovf` are visible from cycle T+34.
- `o_ready`=0 during T+1..T+33 and returns to 1 in T+34, giving a throughput of one value per 34 cycles.
- Reset values:
  - state IDLE, `o_ready`=1, `o_ovf`=0, counter 0.
  - `o_hex0`=7'b1000000 ("0").
  - `o_hex1`..`o_hex7` as defined under Configuration.
- Reset during CONV or DONE aborts the conversion with no partial display update. Reset has priority over all other events on the same edge.
- Value 0 converts normally (32 cycles) and displays "0".

## Configuration
- Macro `BIN2BCD_LZ_BLANK_EN`.
- **Defined:** leading-zero blanking.
  - Every digit above the most significant nonzero digit shows 7'h7F (off).
  - `o_hex0` is never blanked.
  - Overflow dashes are never blanked.
  - Reset value of `o_hex1`..`o_hex7` is 7'h7F.
- **Undefined:** all eight digits are always shown, and the reset value of `o_hex1`..`o_hex7` is 7'b1000000.

## Test plan
- **Reset:** assert `i_rst` 2 cycles → `o_ready`=1, `o_ovf`=0, `o_hex0`=7'b1000000; `o_hex7` = 7'h7F with the macro, 7'b1000000 without.
- **Normal conversion:** send 12_345_678 → `o_ready` low for exactly 33 cycles; from T+34, `o_hex7..o_hex0` = 1,2,3,4,5,6,7,8 encodings (`o_hex7`=7'b1111001, `o_hex0`=7'b0000000), `o_ovf`=0.
- **Blanking:** send 905 → `o_hex2..o_hex0`=9,0,5. With the macro, `o_hex3..o_hex7`=7'h7F; without it, they show 7'b1000000.
- **Overflow boundary:** send 99_999_999 → all digits 7'b0011000, `o_ovf`=0. Then send 100_000_000 → all digits 7'b0111111, `o_ovf`=1. Then send 32'hFFFF_FFFF → dashes, `o_ovf`=1.
- **Busy and stability:**
  - Hold `i_valid`=1 with 7 then 3 back to back → first handshake takes 7.
  - The value 3 is accepted only at cycle T+34 and displayed from T+68.
  - Changing `i_data` mid-conversion does not alter the result.
- **Reset mid-operation:** display 42, start converting 77, assert `i_rst` at T+10 → outputs return to reset values, `o_ready`=1 next cycle, and 77 never appears.
